// File: rtl/cache_pkg.sv
// Shared widths, state encoding and payload types for the direct-mapped
// write-back data cache controller.
package cache_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned TAG_W        = 22;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned OFF_W        = 5;
  localparam int unsigned WSEL_W       = 3;
  localparam int unsigned LINE_W       = 256;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned TE_W         = 24;
  localparam int unsigned TE_VALID_BIT = 23;
  localparam int unsigned TE_DIRTY_BIT = 22;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  // Field order fixes valid at bit 23 and dirty at bit 22.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef struct packed {
    logic              we;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic [WORD_W-1:0] wdata;
  } cpu_req_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, OFF_W'(0)};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag and data arrays: asynchronous read, synchronous write, per-word data
// write enables. Only the tag array is reset.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned WORDS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  idx_i,
  output tag_entry_t        tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              tag_we_i,
  input  tag_entry_t        tag_i,
  input  logic [WORDS-1:0]  word_we_i,
  input  logic [LINE_W-1:0] line_i
);

  tag_entry_t        tags_q [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign tag_o  = tags_q[idx_i];
  assign line_o = data_q[idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LINES; i++) tags_q[i] <= '0;
    end else if (tag_we_i) begin
      tags_q[idx_i] <= tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int w = 0; w < WORDS; w++) begin
      if (word_we_i[w]) data_q[idx_i][w*WORD_W +: WORD_W] <= line_i[w*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller with
// line-granular memory interface and saturating hit/miss statistics.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_e            state_q, state_d;
  cpu_req_t          req_q, req_d;
  logic              refill_q, refill_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  tag_entry_t        rd_tag, tag_wr;
  logic [LINE_W-1:0] rd_line, line_wr;
  logic [WORDS-1:0]  word_we;
  logic              tag_we;
  logic              hit;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  cache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .clk_i     (clk),
    .rst_ni    (rst),
    .idx_i     (req_q.idx),
    .tag_o     (rd_tag),
    .line_o    (rd_line),
    .tag_we_i  (tag_we),
    .tag_i     (tag_wr),
    .word_we_i (word_we),
    .line_i    (line_wr)
  );

  assign hit = rd_tag.valid && (rd_tag.tag == req_q.tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      refill_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      refill_q    <= refill_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // The COMPARE that follows a fill always hits; refill_q keeps it out of
  // hit_cnt so each access is counted exactly once, as a hit or a miss.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    refill_d    = refill_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    tag_we      = 1'b0;
    tag_wr      = '0;
    word_we     = '0;
    line_wr     = mem_rdata;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req && !cpu_ready_q) begin
          req_d = '{we:    cpu_we,
                    tag:   cpu_addr[ADDR_W-1 -: TAG_W],
                    idx:   cpu_addr[OFF_W +: IDX_W],
                    wsel:  cpu_addr[2 +: WSEL_W],
                    wdata: cpu_wdata};
          refill_d = 1'b0;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          if (req_q.we) begin
            word_we = WORDS'(1) << req_q.wsel;
            line_wr = LINE_W'({WORDS{req_q.wdata}});
            tag_we  = 1'b1;
            tag_wr  = '{valid: 1'b1, dirty: 1'b1, tag: req_q.tag};
          end else begin
            cpu_rdata_d = rd_line[req_q.wsel*WORD_W +: WORD_W];
          end
          cpu_ready_d = 1'b1;
          if (!refill_q) hit_cnt_d = sat_inc(hit_cnt_q);
          state_d = S_IDLE;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          mem_req_d  = 1'b1;
          if (rd_tag.valid && rd_tag.dirty) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = line_addr(rd_tag.tag, req_q.idx);
            mem_wdata_d = rd_line;
            state_d     = S_WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = line_addr(req_q.tag, req_q.idx);
            state_d    = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(req_q.tag, req_q.idx);
          state_d    = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          word_we   = '1;
          line_wr   = mem_rdata;
          tag_we    = 1'b1;
          tag_wr    = '{valid: 1'b1, dirty: 1'b0, tag: req_q.tag};
          mem_req_d = 1'b0;
          refill_d  = 1'b1;
          state_d   = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LINES, 32, number of direct-mapped lines (index width 5).
REQ-002 SHALL have parameter WORDS, 8, 32-bit words per line (line width 256, offset 5 bits).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_req, input, 1: CPU access request, held stable until cpu_ready.
REQ-006 SHALL have port cpu_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port cpu_addr, input, 32: byte address; tag [31:10], index [9:5], word [4:2].
REQ-008 SHALL have port cpu_wdata, input, 32: store data.
REQ-009 SHALL have port cpu_rdata, output, 32: load data, valid when cpu_ready = 1.
REQ-010 SHALL have port cpu_ready, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port mem_req, output, 1: memory line transfer request.
REQ-012 SHALL have port mem_we, output, 1: 1 = line write-back, 0 = line fill.
REQ-013 SHALL have port mem_addr, output, 32: line-aligned byte address ([4:0] = 0).
REQ-014 SHALL have port mem_wdata, output, 256: victim line.
REQ-015 SHALL have port mem_rdata, input, 256: fill line, valid when mem_ready = 1.
REQ-016 SHALL have port mem_ready, input, 1: one-cycle transfer-done pulse from memory.
REQ-017 SHALL have ports hit_cnt and miss_cnt, output, 16 each: access statistics.

Function
REQ-018 SHALL keep a tag store of LINES x 24 bits {valid, dirty, tag[21:0]} and a data store of LINES x 256 bits; write-back, write-allocate policy.
REQ-019 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-020 IDLE: when cpu_req = 1 and cpu_ready = 0, SHALL latch addr/we/wdata and go to COMPARE; otherwise stay.
REQ-021 COMPARE hit (valid and tag equal): load SHALL register the selected word into cpu_rdata; store SHALL replace the selected word and set dirty; both SHALL assert cpu_ready for exactly the next cycle, increment hit_cnt, return to IDLE.
REQ-022 COMPARE miss: SHALL increment miss_cnt once per access; go to WRITEBACK if valid and dirty, else ALLOCATE.
REQ-023 WRITEBACK: SHALL drive mem_req = 1, mem_we = 1, mem_addr = {stored tag, index, 5'b0}, mem_wdata = stored line until mem_ready, then go to ALLOCATE.
REQ-024 ALLOCATE: SHALL drive mem_req = 1, mem_we = 0, mem_addr = {request tag, index, 5'b0} until mem_ready; on mem_ready SHALL write mem_rdata to the line, set valid = 1, dirty = 0, tag = request tag, and go to COMPARE (which then hits).
REQ-025 Hit latency: request accepted at edge N, cpu_ready high during cycle N+2.
REQ-026 Miss latency SHALL be hit latency plus memory wait cycles plus 1 (ALLOCATE) or 2 (WRITEBACK then ALLOCATE) state cycles.
REQ-027 mem_req SHALL be 0 in IDLE and COMPARE; outputs of a transfer SHALL stay constant while mem_req = 1.
REQ-028 mem_ready while mem_req = 0 SHALL be ignored.
REQ-029 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF.
REQ-030 Store miss SHALL merge cpu_wdata only after fill (in the second COMPARE), never into the victim line.

Reset
REQ-031 rst = 0 SHALL immediately force state IDLE, cpu_ready = 0, cpu_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, counters = 0, and all tag entries = 24'b0; data store need not reset.
REQ-032 Reset during WRITEBACK or ALLOCATE SHALL abandon the transfer; no partial line is installed.

Structure
REQ-033 Package cache_pkg SHALL hold the state encoding, field widths (TAG_W = 22, IDX_W = 5, OFF_W = 5, LINE_W = 256) and tag-entry bit positions.
REQ-034 Tag and data stores SHALL live in one sub-module cache_line_store (async read, synchronous write, per-word write enable).

Verification
REQ-035 Reset, then load 0x0000_0040 with memory line 2 word 0 = 16 -> ALLOCATE, mem_addr 0x40, cpu_rdata = 16, miss_cnt = 1.
REQ-036 Repeat load 0x0000_0044 -> hit, cpu_ready exactly 2 cycles after accept, hit_cnt = 1, no mem_req.
REQ-037 Store 0xDEAD_BEEF to 0x40, then load 0x0000_0440 (same index, other tag) -> WRITEBACK to mem_addr 0x40 with word 0 = 0xDEAD_BEEF, then ALLOCATE 0x440.
REQ-038 Hold mem_ready low 10 cycles in ALLOCATE -> mem_req, mem_addr stable throughout, cpu_ready stays 0.
REQ-039 Assert rst = 0 mid-ALLOCATE -> mem_req drops same cycle; reload of same address misses again.
REQ-040 Force hit_cnt to 16'hFFFE, do 3 hits -> hit_cnt = 16'hFFFF.
